// File: rtl/aes_inv_key_schedule.sv
// Iterative inverse AES-128 key schedule: loads the round-10 key and streams round keys 10..0.
// Optional build macro AES_INV_KEY_ZEROIZE_EN clears all key material when the sequence ends.

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  // Forward AES S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry i sits at bit offset (255-i)*8, and 255-i equals ~i for an 8-bit index.
  assign out_o = SBOX_TABLE[{~in_i, 3'b000} +: 8];

endmodule

module aes_inv_key_schedule #(
  parameter int          ROUNDS  = 10,
  parameter logic [7:0]  RC_LAST = 8'h36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key_in,
  output logic         busy,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(ROUNDS);

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rc_q, rc_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  w0_n, w1_n, w2_n, w3_n;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [127:0] step_key;
  logic         handshake;

  function automatic logic [7:0] rc_prev(input logic [7:0] rc);
    rc_prev = (rc == 8'h1b) ? 8'h80 : (rc >> 1);
  endfunction

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Undo the forward xor chain first; the recovered w3 feeds the round function.
  assign w3_n  = w3 ^ w2;
  assign w2_n  = w2 ^ w1;
  assign w1_n  = w1 ^ w0;
  assign rot_w = {w3_n[23:0], w3_n[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .in_i  (rot_w[8*gi +: 8]),
        .out_o (sub_w[8*gi +: 8])
      );
    end
  endgenerate

  assign w0_n     = w0 ^ sub_w ^ {rc_q, 24'h0};
  assign step_key = {w0_n, w1_n, w2_n, w3_n};

  assign handshake = (state_q == EMIT) && key_ready;

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    idx_d     = idx_q;
    rc_d      = rc_q;
    busy      = 1'b0;
    key_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = last_key_in;
          idx_d   = LAST_IDX;
          rc_d    = RC_LAST;
          state_d = EMIT;
        end
      end
      EMIT: begin
        key_valid = 1'b1;
        busy      = 1'b1;
        if (handshake) begin
          if (idx_q != 4'd0) begin
            key_d = step_key;
            idx_d = idx_q - 4'd1;
            rc_d  = rc_prev(rc_q);
          end else begin
            state_d = FIN;
`ifdef AES_INV_KEY_ZEROIZE_EN
            key_d = 128'h0;
            rc_d  = 8'h0;
`endif
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= 128'h0;
      idx_q   <= 4'd0;
      rc_q    <= 8'h0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rc_q    <= rc_d;
    end
  end

  assign round_key = key_q;
  assign round_idx = idx_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for aes_inv_key_schedule using the FIPS-197 AES-128 expansion of 2b7e1516...
// Covers reset, full sequence, backpressure, ignored start, mid-sequence reset and Rcon order.

module tb_aes_inv_key_schedule;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] last_key_in;
  logic         busy;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         done;

  int n_checks;
  int n_fail;

  logic [127:0] rk [0:10];
  logic [7:0]   rc_tab [0:10];
  logic [127:0] after_done_key;

  aes_inv_key_schedule dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .last_key_in (last_key_in),
    .busy        (busy),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .round_key   (round_key),
    .round_idx   (round_idx),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sampled at a falling edge; issues start so the first beat is visible one falling edge later.
  task automatic start_seq();
    start       = 1'b1;
    last_key_in = rk[10];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input int idx, input logic rdy);
    key_ready = rdy;
    check_eq($sformatf("valid@%0d", idx), 128'(key_valid), 128'(1'b1));
    check_eq($sformatf("busy@%0d", idx), 128'(busy), 128'(1'b1));
    check_eq($sformatf("idx@%0d", idx), 128'(round_idx), 128'(idx));
    check_eq($sformatf("key@%0d", idx), round_key, rk[idx]);
    check_eq($sformatf("rc@%0d", idx), 128'(dut.rc_q), 128'(rc_tab[idx]));
    $display("beat idx=%0d ready=%0b key=%h", round_idx, rdy, round_key);
    @(negedge clk);
  endtask

  task automatic check_fin(input string tag);
    check_eq({tag, "_done"}, 128'(done), 128'(1'b1));
    check_eq({tag, "_valid"}, 128'(key_valid), 128'(1'b0));
    check_eq({tag, "_busy"}, 128'(busy), 128'(1'b0));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rc_tab = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
`ifdef AES_INV_KEY_ZEROIZE_EN
    after_done_key = 128'h0;
`else
    after_done_key = rk[0];
`endif

    rst         = 1'b1;
    start       = 1'b0;
    key_ready   = 1'b0;
    last_key_in = 128'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 128'(busy), 128'(1'b0));
    check_eq("rst_valid", 128'(key_valid), 128'(1'b0));
    check_eq("rst_done", 128'(done), 128'(1'b0));
    check_eq("rst_idx", 128'(round_idx), 128'(0));
    check_eq("rst_key", round_key, 128'h0);
    check_eq("rst_rc", 128'(dut.rc_q), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Full FIPS-197 walk with the consumer always ready.
    start_seq();
    for (int i = 10; i >= 0; i--) beat(i, 1'b1);
    key_ready = 1'b0;
    check_fin("t1_fin");
    @(negedge clk);
    check_eq("t1_done_pulse", 128'(done), 128'(1'b0));
    check_eq("t1_idle_valid", 128'(key_valid), 128'(1'b0));
    check_eq("t1_after_key", round_key, after_done_key);
    $display("seq1 complete round_key=%h", round_key);

    // Backpressure on idx9 for three cycles.
    start_seq();
    beat(10, 1'b1);
    for (int i = 0; i < 3; i++) beat(9, 1'b0);
    for (int i = 9; i >= 0; i--) beat(i, 1'b1);
    key_ready = 1'b0;
    check_fin("t2_fin");
    @(negedge clk);

    // start pulses during EMIT and during FIN are ignored.
    start_seq();
    for (int i = 10; i >= 7; i--) beat(i, 1'b1);
    start       = 1'b1;
    last_key_in = 128'h0123456789abcdef0123456789abcdef;
    beat(6, 1'b1);
    start = 1'b0;
    for (int i = 5; i >= 0; i--) beat(i, 1'b1);
    key_ready = 1'b0;
    check_fin("t3_fin");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("t3_no_restart_valid", 128'(key_valid), 128'(1'b0));
    check_eq("t3_no_restart_done", 128'(done), 128'(1'b0));
    @(negedge clk);
    check_eq("t3_still_idle", 128'(key_valid), 128'(1'b0));
    check_eq("t3_idle_key", round_key, after_done_key);

    // Reset abandons a sequence at idx5, then a fresh start begins at idx10.
    start_seq();
    for (int i = 10; i >= 6; i--) beat(i, 1'b1);
    check_eq("t4_pre_idx", 128'(round_idx), 128'(5));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t4_valid", 128'(key_valid), 128'(1'b0));
    check_eq("t4_busy", 128'(busy), 128'(1'b0));
    check_eq("t4_idx", 128'(round_idx), 128'(0));
    check_eq("t4_done", 128'(done), 128'(1'b0));
    @(negedge clk);
    check_eq("t4_done_later", 128'(done), 128'(1'b0));
    start_seq();
    for (int i = 10; i >= 0; i--) beat(i, 1'b1);
    key_ready = 1'b0;
    check_fin("t4_fin");
    @(negedge clk);
    check_eq("t4_after_key", round_key, after_done_key);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
